saturn_config_chain: RTL

SATURN_CONFIG_CHAIN -- requirements
Module: saturn_config_chain

---
 rtl/saturn_config_chain.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/saturn_config_chain.sv
// Daisy-chained bus-module configuration controller: CONFIG/UNCNFG/RESET/C=ID commands and chip-select decode.
// Optional macro SATURN_CONFIG_PROTECT_EN rejects CONFIG base writes that overlap an already configured slot.
module saturn_config_chain #(
    parameter int                       NUM_SLOTS = 4,
    parameter logic [20*NUM_SLOTS-1:0]  SLOT_IDS  = 80'h00019_00003_00005_00007
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clk_en,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [1:0]           i_cmd,
    input  logic [19:0]          i_cmd_addr,
    input  logic [19:0]          i_bus_addr,
    output logic [NUM_SLOTS-1:0] o_sel,
    output logic [19:0]          o_id,
    output logic                 o_id_valid,
    output logic                 o_cfg_err,
    output logic                 o_all_cfg
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    localparam logic [1:0] CMD_CONFIG = 2'b00;
    localparam logic [1:0] CMD_UNCNFG = 2'b01;
    localparam logic [1:0] CMD_RESET  = 2'b10;

    localparam logic [1:0] SL_UNCFG = 2'd0;
    localparam logic [1:0] SL_SIZED = 2'd1;
    localparam logic [1:0] SL_CFG   = 2'd2;

    logic [0:0]  state_q, state_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [19:0] opnd_q, opnd_d;

    logic [1:0]  slot_st_q [NUM_SLOTS];
    logic [1:0]  slot_st_d [NUM_SLOTS];
    logic [19:0] mask_q    [NUM_SLOTS];
    logic [19:0] mask_d    [NUM_SLOTS];
    logic [19:0] base_q    [NUM_SLOTS];
    logic [19:0] base_d    [NUM_SLOTS];

    logic [19:0] id_q, id_d;
    logic        id_valid_q, id_valid_d;
    logic        cfg_err_q, cfg_err_d;
    logic        all_cfg_q, all_cfg_d;

    logic [NUM_SLOTS-1:0] tgt_oh;
    logic                 tgt_found;
    logic                 tgt_sized;
    logic [19:0]          tgt_mask;
    logic [19:0]          tgt_id;
    logic [19:0]          new_base;
    logic [NUM_SLOTS-1:0] unc_oh;
    logic [NUM_SLOTS-1:0] sel_oh;

    // Target is the first slot down the chain that is not yet fully configured.
    always_comb begin : target_search
        tgt_oh    = '0;
        tgt_found = 1'b0;
        tgt_sized = 1'b0;
        tgt_mask  = '0;
        tgt_id    = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_st_q[i] != SL_CFG) begin
                tgt_oh    = '0;
                tgt_oh[i] = 1'b1;
                tgt_found = 1'b1;
                tgt_sized = (slot_st_q[i] == SL_SIZED);
                tgt_mask  = mask_q[i];
                tgt_id    = SLOT_IDS[20*i +: 20];
            end
        end
    end

    assign new_base = opnd_q & tgt_mask;

`ifdef SATURN_CONFIG_PROTECT_EN
    logic overlap;

    always_comb begin : overlap_check
        overlap = 1'b0;
        for (int j = 0; j < NUM_SLOTS; j++) begin
            if (slot_st_q[j] == SL_CFG &&
                ((base_q[j] ^ new_base) & mask_q[j] & tgt_mask) == 20'h00000) begin
                overlap = 1'b1;
            end
        end
    end
`endif

    always_comb begin : uncfg_match
        unc_oh = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_st_q[i] == SL_CFG && ((opnd_q ^ base_q[i]) & mask_q[i]) == 20'h00000) begin
                unc_oh    = '0;
                unc_oh[i] = 1'b1;
            end
        end
    end

    // Overlapping windows resolve to the lowest-index slot.
    always_comb begin : sel_decode
        sel_oh = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_st_q[i] == SL_CFG && ((i_bus_addr ^ base_q[i]) & mask_q[i]) == 20'h00000) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin : next_state
        state_d    = state_q;
        cmd_d      = cmd_q;
        opnd_d     = opnd_q;
        slot_st_d  = slot_st_q;
        mask_d     = mask_q;
        base_d     = base_q;
        id_d       = id_q;
        id_valid_d = id_valid_q;
        cfg_err_d  = cfg_err_q;
        all_cfg_d  = all_cfg_q;
        if (i_clk_en) begin
            id_valid_d = 1'b0;
            cfg_err_d  = 1'b0;
            if (state_q == ST_IDLE) begin
                if (i_cmd_valid) begin
                    state_d = ST_EXEC;
                    cmd_d   = i_cmd;
                    opnd_d  = i_cmd_addr;
                end
            end else begin
                state_d = ST_IDLE;
                case (cmd_q)
                    CMD_CONFIG: begin
                        if (!tgt_found) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            for (int i = 0; i < NUM_SLOTS; i++) begin
                                if (tgt_oh[i]) begin
                                    if (!tgt_sized) begin
                                        mask_d[i]    = opnd_q;
                                        slot_st_d[i] = SL_SIZED;
                                    end else begin
`ifdef SATURN_CONFIG_PROTECT_EN
                                        if (overlap) begin
                                            slot_st_d[i] = SL_UNCFG;
                                            mask_d[i]    = '0;
                                            cfg_err_d    = 1'b1;
                                        end else begin
                                            base_d[i]    = new_base;
                                            slot_st_d[i] = SL_CFG;
                                        end
`else
                                        base_d[i]    = new_base;
                                        slot_st_d[i] = SL_CFG;
`endif
                                    end
                                end
                            end
                        end
                    end
                    CMD_UNCNFG: begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (unc_oh[i]) begin
                                slot_st_d[i] = SL_UNCFG;
                                mask_d[i]    = '0;
                                base_d[i]    = '0;
                            end
                        end
                    end
                    CMD_RESET: begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            slot_st_d[i] = SL_UNCFG;
                            mask_d[i]    = '0;
                            base_d[i]    = '0;
                        end
                    end
                    default: begin
                        // C=ID: tgt_id is already zero when every slot is configured.
                        id_d       = tgt_id;
                        id_valid_d = 1'b1;
                    end
                endcase
            end
            all_cfg_d = 1'b1;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (slot_st_d[i] != SL_CFG) all_cfg_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            id_q       <= '0;
            id_valid_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            all_cfg_q  <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_st_q[i] <= SL_UNCFG;
                mask_q[i]    <= '0;
                base_q[i]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            id_valid_q <= id_valid_d;
            cfg_err_q  <= cfg_err_d;
            all_cfg_q  <= all_cfg_d;
            slot_st_q  <= slot_st_d;
            mask_q     <= mask_d;
            base_q     <= base_d;
        end
    end

    // Latched command operands only matter in EXEC, so they carry no reset.
    always_ff @(posedge i_clk) begin
        cmd_q  <= cmd_d;
        opnd_q <= opnd_d;
    end

    assign o_cmd_ready = (state_q == ST_IDLE);
    assign o_sel       = sel_oh;
    assign o_id        = id_q;
    assign o_id_valid  = id_valid_q;
    assign o_cfg_err   = cfg_err_q;
    assign o_all_cfg   = all_cfg_q;

endmodule
